// File: rtl/id_pkg.sv
// Shared decode types and constants for the ID stage.
package id_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    typedef enum logic [1:0] {
        AluAdd    = 2'b00,
        AluBranch = 2'b01,
        AluR      = 2'b10,
        AluI      = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   alusrc;
        logic   mem2reg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        aluop_e aluop;
    } ctrl_t;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic idx_in_range(logic [4:0] idx, int unsigned n);
        return 32'(idx) < n;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational hazard detection for ID: load-use stalls, branch-operand stalls and
// EX/MEM forward selection (the last two only with ID_BRANCH_RESOLVE_EN).
module id_hazard_unit
    import id_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       is_branch,
    input  logic       idex_valid,
    input  logic [4:0] idex_rd,
    input  logic       idex_memread,
    input  logic       idex_regwrite,
    input  logic [4:0] mem_rd,
    input  logic       mem_memread,
    input  logic       mem_regwrite,
    output logic       stall,
    output logic       fwd_rs1,
    output logic       fwd_rs2
);

    logic idex_hit;
    logic load_use;

    assign idex_hit = (idex_rd != 5'd0) &&
                      ((use_rs1 && idex_rd == rs1) || (use_rs2 && idex_rd == rs2));
    assign load_use = idex_valid && idex_memread && idex_hit;

`ifdef ID_BRANCH_RESOLVE_EN
    logic mem_hit;
    logic br_ex_wait;
    logic br_mem_wait;

    assign mem_hit = (mem_rd != 5'd0) &&
                     ((use_rs1 && mem_rd == rs1) || (use_rs2 && mem_rd == rs2));
    // A branch compares in ID, so any in-flight producer not yet forwardable blocks it.
    assign br_ex_wait  = is_branch && idex_valid && idex_regwrite && idex_hit;
    assign br_mem_wait = is_branch && mem_memread && mem_hit;

    assign stall   = load_use || br_ex_wait || br_mem_wait;
    assign fwd_rs1 = mem_regwrite && !mem_memread && (mem_rd != 5'd0) && (mem_rd == rs1);
    assign fwd_rs2 = mem_regwrite && !mem_memread && (mem_rd != 5'd0) && (mem_rd == rs2);
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{is_branch, idex_regwrite, mem_rd, mem_memread, mem_regwrite};

    assign stall   = load_use;
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, decoder, immediate generation, hazards and the ID/EX register.
// Define ID_BRANCH_RESOLVE_EN to resolve conditional branches in ID.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_regwrite,
    input  logic            mem_memread,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic            ex_stall,
    output logic            id_stall,
    output logic            flush_if,
    output logic [XLEN-1:0] branch_target,
    output logic            valid_idex,
    output logic [XLEN-1:0] pc_idex,
    output logic [31:0]     instr_idex,
    output logic [XLEN-1:0] rs1_data_idex,
    output logic [XLEN-1:0] rs2_data_idex,
    output logic [XLEN-1:0] imm_idex,
    output logic [4:0]      rd_idex,
    output ctrl_t           ctrl_idex,
    output logic            br_taken_idex
);

    localparam int unsigned IdxW = idx_width(NREG);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2;
    ctrl_t           ctrl;
    logic            use_rs1, use_rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rf_q [NREG];
    logic            rf_we;
    logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
    logic            hz_stall, fwd_rs1, fwd_rs2;
    logic            stall_req;
    logic            br_taken;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    always_comb begin
        ctrl    = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm     = '0;
        case (opcode)
            OpcR: begin
                ctrl.aluop    = AluR;
                ctrl.regwrite = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OpcImm: begin
                ctrl.aluop    = AluI;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                use_rs1       = 1'b1;
                imm           = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            OpcLoad: begin
                ctrl.aluop    = AluAdd;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.mem2reg  = 1'b1;
                ctrl.regwrite = 1'b1;
                use_rs1       = 1'b1;
                imm           = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            OpcStore: begin
                ctrl.aluop    = AluAdd;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                imm           = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OpcBranch: begin
                ctrl.aluop  = AluBranch;
                ctrl.branch = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                imm         = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                               if_instr[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    assign rf_we = wb_regwrite && (wb_rd != 5'd0) && idx_in_range(wb_rd, NREG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[wb_rd[IdxW-1:0]] <= wb_data;
        end
    end

    // Write-through: a same-cycle WB write is visible to the read.
    always_comb begin
        rs1_rf = '0;
        rs2_rf = '0;
        if (rs1 != 5'd0 && idx_in_range(rs1, NREG)) begin
            rs1_rf = (rf_we && wb_rd == rs1) ? wb_data : rf_q[rs1[IdxW-1:0]];
        end
        if (rs2 != 5'd0 && idx_in_range(rs2, NREG)) begin
            rs2_rf = (rf_we && wb_rd == rs2) ? wb_data : rf_q[rs2[IdxW-1:0]];
        end
    end

    id_hazard_unit u_hazard (
        .rs1          (rs1),
        .rs2          (rs2),
        .use_rs1      (use_rs1),
        .use_rs2      (use_rs2),
        .is_branch    (ctrl.branch),
        .idex_valid   (valid_idex),
        .idex_rd      (rd_idex),
        .idex_memread (ctrl_idex.memread),
        .idex_regwrite(ctrl_idex.regwrite),
        .mem_rd       (mem_rd),
        .mem_memread  (mem_memread),
        .mem_regwrite (mem_regwrite),
        .stall        (hz_stall),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2)
    );

    assign rs1_val = fwd_rs1 ? mem_alu_result : rs1_rf;
    assign rs2_val = fwd_rs2 ? mem_alu_result : rs2_rf;

`ifdef ID_BRANCH_RESOLVE_EN
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3Beq:   br_taken = (rs1_val == rs2_val);
            F3Bne:   br_taken = (rs1_val != rs2_val);
            F3Blt:   br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3Bge:   br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3Bltu:  br_taken = (rs1_val <  rs2_val);
            F3Bgeu:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end
`else
    logic unused_funct3;
    assign unused_funct3 = ^funct3;
    assign br_taken      = 1'b0;
`endif

    assign stall_req     = if_valid && hz_stall;
    assign id_stall      = ex_stall || stall_req;
    assign flush_if      = if_valid && ctrl.branch && br_taken && !id_stall;
    assign branch_target = flush_if ? (if_pc + imm) : '0;

    // Bubbles clear only valid/ctrl/br_taken; the payload is left as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_idex    <= 1'b0;
            pc_idex       <= '0;
            instr_idex    <= '0;
            rs1_data_idex <= '0;
            rs2_data_idex <= '0;
            imm_idex      <= '0;
            rd_idex       <= '0;
            ctrl_idex     <= '0;
            br_taken_idex <= 1'b0;
        end else if (!ex_stall) begin
            if (if_valid && !stall_req) begin
                valid_idex    <= 1'b1;
                pc_idex       <= if_pc;
                instr_idex    <= if_instr;
                rs1_data_idex <= rs1_val;
                rs2_data_idex <= rs2_val;
                imm_idex      <= imm;
                rd_idex       <= if_instr[11:7];
                ctrl_idex     <= ctrl;
                br_taken_idex <= ctrl.branch && br_taken;
            end else begin
                valid_idex    <= 1'b0;
                ctrl_idex     <= '0;
                br_taken_idex <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomised and directed bench for id_stage_pipe against a behavioural reference model.
// Honours ID_BRANCH_RESOLVE_EN when defined.
module tb_id_stage_pipe;
    import id_pkg::*;

`ifdef ID_BRANCH_RESOLVE_EN
    localparam bit BrEn = 1'b1;
`else
    localparam bit BrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_regwrite, mem_memread;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic        ex_stall;
    logic        id_stall, flush_if;
    logic [31:0] branch_target;
    logic        valid_idex;
    logic [31:0] pc_idex, instr_idex, rs1_data_idex, rs2_data_idex, imm_idex;
    logic [4:0]  rd_idex;
    ctrl_t       ctrl_idex;
    logic        br_taken_idex;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_regwrite  (mem_regwrite),
        .mem_memread   (mem_memread),
        .mem_rd        (mem_rd),
        .mem_alu_result(mem_alu_result),
        .ex_stall      (ex_stall),
        .id_stall      (id_stall),
        .flush_if      (flush_if),
        .branch_target (branch_target),
        .valid_idex    (valid_idex),
        .pc_idex       (pc_idex),
        .instr_idex    (instr_idex),
        .rs1_data_idex (rs1_data_idex),
        .rs2_data_idex (rs2_data_idex),
        .imm_idex      (imm_idex),
        .rd_idex       (rd_idex),
        .ctrl_idex     (ctrl_idex),
        .br_taken_idex (br_taken_idex)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: architectural registers and the expected ID/EX contents.
    typedef struct {
        logic        v;
        logic [31:0] pc, instr, a, b, imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        br;
    } idex_t;

    logic [31:0] ref_rf [32];
    idex_t       m, m_nxt;
    logic        exp_stall, exp_flush;
    logic [31:0] exp_target;
    logic        last_stall, last_flush;
    logic [31:0] last_target;
    int unsigned stall_cnt;

    // Downstream pipeline the bench plays: EX/MEM and MEM/WB occupancy.
    logic        p_mem_v, p_mem_rw, p_mem_mr, p_wb_v, p_wb_rw;
    logic [4:0]  p_mem_rd, p_wb_rd;
    logic        ex_stall_r;
    logic        ov_wb;
    logic [4:0]  ov_rd;
    logic [31:0] ov_data;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } slot_t;
    slot_t prog[$];

    function automatic logic [7:0] ref_ctrl(logic [6:0] op);
        // {alusrc, mem2reg, regwrite, memread, memwrite, branch, aluop[1:0]}
        case (op)
            7'b0110011: return 8'b0010_0010;
            7'b0010011: return 8'b1010_0011;
            7'b0000011: return 8'b1111_0000;
            7'b0100011: return 8'b1000_1000;
            7'b1100011: return 8'b0000_0101;
            default:    return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(logic [31:0] ins);
        int s;
        s = ins;
        case (ins[6:0])
            7'b0010011, 7'b0000011: return 32'(s >>> 20);
            7'b0100011: return 32'((s >>> 25) * 32) + 32'(ins[11:7]);
            7'b1100011: return 32'((s >>> 31) * 4096) + 32'(ins[7]) * 2048
                               + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic src_hit(logic [4:0] rd, logic [31:0] ins);
        logic u1, u2;
        u1 = ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        u2 = ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (rd != 0) && ((u1 && rd == ins[19:15]) || (u2 && rd == ins[24:20]));
    endfunction

    function automatic logic [31:0] rf_read(logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_regwrite && wb_rd == r) return wb_data;
        return ref_rf[r];
    endfunction

    function automatic logic [31:0] opnd(logic [4:0] r);
        if (BrEn && mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == r)
            return mem_alu_result;
        return rf_read(r);
    endfunction

    task automatic model_eval();
        logic        haz, is_br, taken;
        logic [31:0] a, b, imm;
        logic [7:0]  c;
        c     = ref_ctrl(if_instr[6:0]);
        is_br = (if_instr[6:0] == 7'b1100011);
        imm   = ref_imm(if_instr);
        a     = opnd(if_instr[19:15]);
        b     = opnd(if_instr[24:20]);
        haz   = if_valid && m.v && m.ctrl[4] && src_hit(m.rd, if_instr);
        taken = 1'b0;
        if (BrEn && if_valid && is_br) begin
            if (m.v && m.ctrl[5] && src_hit(m.rd, if_instr)) haz = 1'b1;
            if (mem_memread && src_hit(mem_rd, if_instr)) haz = 1'b1;
            case (if_instr[14:12])
                3'b000:  taken = (a == b);
                3'b001:  taken = (a != b);
                3'b100:  taken = ($signed(a) < $signed(b));
                3'b101:  taken = ($signed(a) >= $signed(b));
                3'b110:  taken = (a < b);
                3'b111:  taken = (a >= b);
                default: taken = 1'b0;
            endcase
        end
        exp_stall  = ex_stall || haz;
        exp_flush  = if_valid && is_br && taken && !exp_stall;
        exp_target = exp_flush ? if_pc + imm : 32'd0;
        m_nxt = m;
        if (!ex_stall) begin
            if (if_valid && !haz) begin
                m_nxt.v = 1'b1; m_nxt.pc = if_pc; m_nxt.instr = if_instr;
                m_nxt.a = a; m_nxt.b = b; m_nxt.imm = imm; m_nxt.rd = if_instr[11:7];
                m_nxt.ctrl = c; m_nxt.br = is_br && taken;
            end else begin
                m_nxt.v = 1'b0; m_nxt.ctrl = 8'd0; m_nxt.br = 1'b0;
            end
        end
    endtask

    task automatic model_commit();
        p_wb_v = p_mem_v; p_wb_rw = p_mem_rw; p_wb_rd = p_mem_rd;
        p_mem_v  = !ex_stall && m.v;
        p_mem_rw = m.ctrl[5];
        p_mem_mr = m.ctrl[4];
        p_mem_rd = m.rd;
        if (wb_regwrite && wb_rd != 0) ref_rf[wb_rd] = wb_data;
        m = m_nxt;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        m.v = 0; m.pc = 0; m.instr = 0; m.a = 0; m.b = 0; m.imm = 0; m.rd = 0;
        m.ctrl = 0; m.br = 0;
        p_mem_v = 0; p_mem_rw = 0; p_mem_mr = 0; p_mem_rd = 0;
        p_wb_v = 0; p_wb_rw = 0; p_wb_rd = 0;
        ex_stall_r = 0; ov_wb = 0; ov_rd = 0; ov_data = 0;
        prog.delete();
    endtask

    task automatic drive();
        if (prog.size() > 0) begin
            if_valid = 1'b1; if_instr = prog[0].instr; if_pc = prog[0].pc;
        end else begin
            if_valid = 1'b0; if_instr = $urandom; if_pc = $urandom;
        end
        mem_regwrite   = p_mem_v && p_mem_rw;
        mem_memread    = p_mem_v && p_mem_mr;
        mem_rd         = p_mem_rd;
        mem_alu_result = $urandom;
        if (ov_wb) begin
            wb_regwrite = 1'b1; wb_rd = ov_rd; wb_data = ov_data; ov_wb = 1'b0;
        end else begin
            wb_regwrite = p_wb_v && p_wb_rw; wb_rd = p_wb_rd; wb_data = $urandom;
        end
        ex_stall = ex_stall_r;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        drive();
        #1;
        model_eval();
        last_stall = id_stall; last_flush = flush_if; last_target = branch_target;
        check_eq("id_stall", 32'(id_stall), 32'(exp_stall));
        check_eq("flush_if", 32'(flush_if), 32'(exp_flush));
        check_eq("branch_target", branch_target, exp_target);
        if (id_stall === 1'b1) stall_cnt++;
        if (prog.size() > 0 && !exp_stall) void'(prog.pop_front());
        @(posedge clk);
        #1;
        model_commit();
        check_eq("valid_idex", 32'(valid_idex), 32'(m.v));
        check_eq("pc_idex", pc_idex, m.pc);
        check_eq("instr_idex", instr_idex, m.instr);
        check_eq("rs1_data_idex", rs1_data_idex, m.a);
        check_eq("rs2_data_idex", rs2_data_idex, m.b);
        check_eq("imm_idex", imm_idex, m.imm);
        check_eq("rd_idex", 32'(rd_idex), 32'(m.rd));
        check_eq("ctrl_idex", 32'(ctrl_idex), 32'(m.ctrl));
        check_eq("br_taken_idex", 32'(br_taken_idex), 32'(m.br));
        @(negedge clk);
    endtask

    task automatic push(logic [31:0] pc, logic [31:0] ins);
        slot_t s;
        s.pc = pc; s.instr = ins;
        prog.push_back(s);
    endtask

    task automatic run(int max);
        for (int k = 0; k < max && prog.size() > 0; k++) cycle();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wb_force(logic [4:0] rd, logic [31:0] data);
        ov_wb = 1'b1; ov_rd = rd; ov_data = data;
    endtask

    function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, int rd, int rs1,
                                          int imm);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_b(logic [2:0] f3, int rs1, int rs2, int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), f3, b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [6];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 5)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw5;
        model_reset();
        stall_cnt = 0;

        // Reset with a live instruction presented.
        rst_n = 1'b0;
        if_valid = 1'b1; if_instr = enc_r(3, 1, 2); if_pc = 32'h40;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        mem_regwrite = 0; mem_memread = 0; mem_rd = 0; mem_alu_result = 0; ex_stall = 0;
        #22;
        check_eq("rst valid_idex", 32'(valid_idex), 32'd0);
        check_eq("rst pc_idex", pc_idex, 32'd0);
        check_eq("rst instr_idex", instr_idex, 32'd0);
        check_eq("rst rs1_data", rs1_data_idex, 32'd0);
        check_eq("rst rs2_data", rs2_data_idex, 32'd0);
        check_eq("rst imm_idex", imm_idex, 32'd0);
        check_eq("rst rd_idex", 32'(rd_idex), 32'd0);
        check_eq("rst ctrl_idex", 32'(ctrl_idex), 32'd0);
        check_eq("rst br_taken", 32'(br_taken_idex), 32'd0);
        check_eq("rst id_stall", 32'(id_stall), 32'd0);
        check_eq("rst flush_if", 32'(flush_if), 32'd0);
        check_eq("rst branch_target", branch_target, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h0, enc_r(3, 1, 2));
        cycle();
        check_eq("first valid", 32'(valid_idex), 32'd1);
        check_eq("first aluop", 32'(ctrl_idex.aluop), 32'd2);
        check_eq("first rd", 32'(rd_idex), 32'd3);

        // Load-use: exactly one stall cycle.
        lw5 = enc_i(7'b0000011, 3'b010, 5, 1, 0);
        stall_cnt = 0;
        push(32'h4, lw5);
        push(32'h8, enc_r(6, 5, 2));
        run(10);
        check_eq("load-use stalls", stall_cnt, 32'd1);
        idle(3);

        // Write-through and x0.
        wb_force(5'd7, 32'hDEADBEEF);
        push(32'h10, enc_r(8, 7, 0));
        cycle();
        check_eq("wb bypass x7", rs1_data_idex, 32'hDEADBEEF);
        wb_force(5'd0, 32'hFFFF_FFFF);
        push(32'h14, enc_r(9, 0, 0));
        cycle();
        check_eq("x0 same cycle", rs1_data_idex, 32'd0);
        push(32'h18, enc_r(10, 0, 0));
        cycle();
        check_eq("x0 after write", rs1_data_idex, 32'd0);
        idle(3);

        // Branch resolution in ID.
        wb_force(5'd1, 32'd5);
        cycle();
        wb_force(5'd2, 32'd5);
        cycle();
        push(32'h100, enc_b(3'b000, 1, 2, 16));
        cycle();
        check_eq("beq flush", 32'(last_flush), 32'(BrEn));
        check_eq("beq target", last_target, BrEn ? 32'h110 : 32'h0);
        push(32'h104, enc_b(3'b001, 1, 2, 16));
        cycle();
        check_eq("bne flush", 32'(last_flush), 32'd0);
        idle(3);

        stall_cnt = 0;
        push(32'h200, enc_i(7'b0000011, 3'b010, 1, 2, 0));
        push(32'h204, enc_b(3'b000, 1, 0, 8));
        run(10);
        check_eq("lw-beq stalls", stall_cnt, BrEn ? 32'd2 : 32'd1);
        idle(3);
        stall_cnt = 0;
        push(32'h300, enc_i(7'b0010011, 3'b000, 1, 0, 1));
        push(32'h304, enc_b(3'b000, 1, 0, 8));
        run(10);
        check_eq("addi-beq stalls", stall_cnt, BrEn ? 32'd1 : 32'd0);
        idle(3);

        // EX backpressure during a load-use stall.
        push(32'h400, lw5);
        push(32'h404, enc_r(6, 5, 2));
        cycle();
        ex_stall_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("exs held instr", instr_idex, lw5);
            check_eq("exs id_stall", 32'(last_stall), 32'd1);
        end
        ex_stall_r = 1'b0;
        run(10);
        check_eq("exs resumed instr", instr_idex, enc_r(6, 5, 2));
        idle(3);

        // Asynchronous reset in the middle of a stall.
        push(32'h500, lw5);
        push(32'h504, enc_r(6, 5, 2));
        cycle();
        ex_stall_r = 1'b1;
        cycle();
        #2;
        ex_stall = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("async rst valid", 32'(valid_idex), 32'd0);
        check_eq("async rst instr", instr_idex, 32'd0);
        check_eq("async rst ctrl", 32'(ctrl_idex), 32'd0);
        check_eq("async rst stall", 32'(id_stall), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            if (prog.size() < 2) push(32'($urandom) & 32'hFFFF_FFFC, rand_instr());
            ex_stall_r = ($urandom_range(0, 9) == 0);
            cycle();
        end
        ex_stall_r = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
